// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - op codes and classification helpers for the multiply/divide unit
package mdu_pkg;

    typedef enum logic [3:0] {
        MDU_MULT  = 4'd0,
        MDU_MULTU = 4'd1,
        MDU_DIV   = 4'd2,
        MDU_DIVU  = 4'd3,
        MDU_MTHI  = 4'd4,
        MDU_MTLO  = 4'd5,
        MDU_MADD  = 4'd6,
        MDU_MADDU = 4'd7,
        MDU_MSUB  = 4'd8,
        MDU_MSUBU = 4'd9
    } mdu_op_e;

    // Any code above the last defined op is a NOP.
    function automatic logic is_mdu_valid_op(input logic [3:0] op);
        return op <= MDU_MSUBU;
    endfunction

    // Ops that occupy the unit for a latency window; the hazard unit stalls on these.
    function automatic logic is_mdu_busy_op(input logic [3:0] op);
        return is_mdu_valid_op(op) && (op != MDU_MTHI) && (op != MDU_MTLO);
    endfunction

    function automatic logic is_mdu_div_op(input logic [3:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - multi-cycle multiply/divide unit with HI/LO registers
// Ports:
//   clk, reset (async active-low)
//   start, op, d1, d2 : request strobe, op code, rs/rt operands
//   cancel            : flush of any in-flight operation
//   busy              : operation in flight
//   hi, lo            : architectural HI/LO registers
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic             cancel,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);

    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    logic               accept;
    logic [CW-1:0]      lat;
    logic [WIDTH-1:0]   n_hi;
    logic [WIDTH-1:0]   n_lo;

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] sprod;
    logic [2*WIDTH-1:0] uprod;
    logic [2*WIDTH-1:0] mres;

    logic signed [WIDTH-1:0] sd1;
    logic signed [WIDTH-1:0] sd2;
    logic signed [WIDTH-1:0] sq;
    logic signed [WIDTH-1:0] sr;
    logic [WIDTH-1:0]        uq;
    logic [WIDTH-1:0]        ur;
    logic                    div_zero;
    logic                    div_ovf;

    assign busy   = (count != '0);
    assign accept = start && !busy && !cancel && is_mdu_valid_op(op);

    assign acc = {hi, lo};
    // Products are taken mod 2^(2W): multiplying the sign-extended operands
    // gives the signed product, zero-extension gives the unsigned one.
    assign sprod = {{WIDTH{d1[WIDTH-1]}}, d1} * {{WIDTH{d2[WIDTH-1]}}, d2};
    assign uprod = {{WIDTH{1'b0}}, d1} * {{WIDTH{1'b0}}, d2};

    assign sd1      = d1;
    assign sd2      = d2;
    assign sq       = sd1 / sd2;
    assign sr       = sd1 % sd2;
    assign uq       = d1 / d2;
    assign ur       = d1 % d2;
    assign div_zero = (d2 == '0);
    assign div_ovf  = (d1 == {1'b1, {(WIDTH-1){1'b0}}}) && (d2 == '1);

    always_comb begin
        n_hi = hi;
        n_lo = lo;
        mres = '0;
        lat  = '0;
        if (is_mdu_busy_op(op)) begin
            lat = is_mdu_div_op(op) ? CW'(DIV_LAT) : CW'(MULT_LAT);
        end
        case (op)
            MDU_MULT:  mres = sprod;
            MDU_MULTU: mres = uprod;
            MDU_MADD:  mres = acc + sprod;
            MDU_MADDU: mres = acc + uprod;
            MDU_MSUB:  mres = acc - sprod;
            MDU_MSUBU: mres = acc - uprod;
            default:   mres = acc;
        endcase
        case (op)
            MDU_MULT, MDU_MULTU, MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU: begin
                n_hi = mres[2*WIDTH-1:WIDTH];
                n_lo = mres[WIDTH-1:0];
            end
            MDU_DIV: begin
                if (div_zero) begin
                    n_hi = d1;
                    n_lo = '1;
                end else if (div_ovf) begin
                    n_hi = '0;
                    n_lo = d1;
                end else begin
                    n_hi = sr;
                    n_lo = sq;
                end
            end
            MDU_DIVU: begin
                if (div_zero) begin
                    n_hi = d1;
                    n_lo = '1;
                end else begin
                    n_hi = ur;
                    n_lo = uq;
                end
            end
            MDU_MTHI: n_hi = d1;
            MDU_MTLO: n_lo = d1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count  <= '0;
            res_hi <= '0;
            res_lo <= '0;
            hi     <= '0;
            lo     <= '0;
        end else if (cancel) begin
            // Also covers cancel on the committing edge: the commit branch is skipped.
            count  <= '0;
            res_hi <= '0;
            res_lo <= '0;
        end else if (accept) begin
            if (lat == '0) begin
                hi <= n_hi;
                lo <= n_lo;
            end else begin
                count  <= lat;
                res_hi <= n_hi;
                res_lo <= n_lo;
            end
        end else if (busy) begin
            count <= count - 1'b1;
            if (count == CW'(1)) begin
                hi <= res_hi;
                lo <= res_lo;
            end
        end
    end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Parametrised multi-cycle multiply/divide unit with HI/LO accumulator registers, sitting in the Execute stage beside the ALU. Accepts one operation per `start` pulse, holds `busy` for a per-class configurable latency, then commits the result to HI/LO. It adds multiply-accumulate/subtract, defined divide-by-zero and overflow results, and a `cancel` input for pipeline flushes. All widths are generic.

## Interface
- `WIDTH`, 32: operand and HI/LO width, ≥ 2.
- `MULT_LAT`, 5: busy cycles for MULT/MULTU/MADD*/MSUB*, ≥ 1.
- `DIV_LAT`, 10: busy cycles for DIV/DIVU, ≥ 1.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low. Clears all state.
- `start`  in  1  request strobe, sampled on the rising edge.
- `op`  in  4  operation code from `mdu_pkg`.
- `d1`  in  WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO data).
- `d2`  in  WIDTH  rt operand (divisor / multiplier).
- `cancel`  in  1  abort of any in-flight operation.
- `busy`  out  1  operation in flight; reset 0.
- `hi`  out  WIDTH  HI register; reset 0.
- `lo`  out  WIDTH  LO register; reset 0.

## Operation
- Ops:
  - MULT and MULTU: {HI,LO} = d1*d2, signed and unsigned respectively.
  - MADD and MADDU: {HI,LO} += d1*d2.
  - MSUB and MSUBU: {HI,LO} −= d1*d2.
  - DIV and DIVU: LO = quotient, HI = remainder.
  - MTHI: HI = d1. MTLO: LO = d1.
  - Any other code is a NOP.
- Accept condition: `start` & ~`busy` & ~`cancel` & valid op. Otherwise `start` is ignored, with no queueing.
- On accept, the result is computed from d1/d2 and the current HI/LO, and stored in pending registers `res_hi`/`res_lo`. The down-counter is loaded with `MULT_LAT` or `DIV_LAT`.
- Accumulate arithmetic is 2·WIDTH bits, modulo 2^(2·WIDTH). Signed variants sign-extend the product; unsigned variants zero-extend it.
- Division truncates toward zero. The remainder takes the sign of the dividend.
- Divide by zero (both variants): LO = all-ones, HI = d1.
- Signed overflow (d1 = most-negative, d2 = −1): LO = d1, HI = 0.
- MTHI/MTLO are only accepted when not busy. They write on the accept edge, never assert `busy`, and leave the other register untouched.
- `busy` = (counter ≠ 0).
- When the counter goes 1→0, HI/LO ← pending registers.
- `cancel` while busy:
  - Counter is cleared and pending results are discarded.
  - HI/LO keep their pre-operation values.
  - `cancel` has priority over `start` in the same cycle, so that `start` is dropped.
- `reset` asserted mid-operation: counter, pending registers, HI and LO all go to 0 immediately (asynchronous).

## Timing
- Accept on edge N. `busy` is high for cycles N+1 … N+LAT, exactly LAT cycles.
- HI/LO update on edge N+LAT. New values are visible in the same cycle `busy` falls.
- A new `start` can be accepted on edge N+LAT+1, the first cycle with `busy` low, giving back-to-back throughput of LAT+1 cycles.
- MTHI/MTLO: zero-latency commit. The new value is visible the cycle after accept.
- `cancel` at edge C (N < C ≤ N+LAT−1): `busy` is low from C onward. If `cancel` coincides with the committing edge N+LAT, the commit is suppressed.
- Counter width is $clog2(max(MULT_LAT, DIV_LAT)+1).
- Outputs are all registered; there are no combinational paths from inputs to outputs.

## Structure
- `mdu_pkg` holds:
  - the op enumeration (`MDU_MULT`, `MDU_MULTU`, `MDU_DIV`, `MDU_DIVU`, `MDU_MTHI`, `MDU_MTLO`, `MDU_MADD`, `MDU_MADDU`, `MDU_MSUB`, `MDU_MSUBU`);
  - an `is_mdu_busy_op` function, also used by the hazard unit for stall generation.
- Single module. Arithmetic is behavioural and inline; no sub-module is required.
- A later iterative divider is slotted in as `mdu_div_iter` behind the same counter interface.

## Test plan
All scenarios use WIDTH=32, MULT_LAT=5, DIV_LAT=10.
- MULT d1=0xFFFFFFFF, d2=2 → `busy` high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE. MULTU with the same operands → HI=0x00000001, LO=0xFFFFFFFE.
- DIV d1=0xFFFFFFF9 (−7), d2=2 → after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/2 → LO=3, HI=1.
- Divide by zero, DIV 5/0 → LO=0xFFFFFFFF, HI=5. Overflow, DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- MTLO 0xFFFFFFFF, MTHI 0, then MADDU 1·1 → HI=1, LO=0. Then MSUB 1·1 → HI=0, LO=0xFFFFFFFF.
- Start MULT with HI=0xA, LO=0xB, then:
  - a second `start` in busy cycle 2 is ignored;
  - `cancel` in busy cycle 3 drops `busy` next cycle;
  - HI/LO stay 0xA/0xB;
  - a new `start` is accepted the following cycle.
- Drive `reset` low during busy cycle 4 of a DIV → `busy`, HI and LO read 0 immediately. After `reset` is released, no stale commit occurs.
